cpu_controller: RTL and testbench



---
 rtl/cpu_controller_if.sv | 44 ++++
 rtl/cpu_controller.sv | 145 ++++++++++++++
 tb/tb_cpu_controller.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : cpu_controller_pkg / cpu_controller_if
// Description : Opcode type and the controller-to-datapath strobe bundle.
// Revision    : 1.0  initial release
// ============================================================================
package cpu_controller_pkg;
    typedef enum logic [2:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_t;
endpackage

interface cpu_controller_if;
    import cpu_controller_pkg::*;

    opcode_t    opcode;
    logic       zero;
    logic       mem_rd;
    logic       mem_wr;
    logic       load_ir;
    logic       load_ac;
    logic       inc_pc;
    logic       load_pc;
    logic       halt;
    logic [2:0] phase;

    modport master (
        input  opcode, zero,
        output mem_rd, mem_wr, load_ir, load_ac, inc_pc, load_pc, halt, phase
    );

    modport slave (
        output opcode, zero,
        input  mem_rd, mem_wr, load_ir, load_ac, inc_pc, load_pc, halt, phase
    );
endinterface
`default_nettype wire

// File: rtl/cpu_controller.sv
`default_nettype none
// ============================================================================
// Module      : cpu_controller
// Description : 8-phase instruction sequencer decoding the IR opcode into
//               datapath strobes. Optional macro CTRL_SINGLE_STEP_EN adds a
//               step input that gates each instruction from INST_ADDR.
// Revision    : 1.0  initial release
// ============================================================================
module cpu_controller
    import cpu_controller_pkg::*;
#(
    parameter int HALT_STICKY = 1
) (
    input  wire logic          clk,
    input  wire logic          rst_,
`ifdef CTRL_SINGLE_STEP_EN
    input  wire logic          step,
`endif
    cpu_controller_if.master   bus
);

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_t;

    phase_t r_phase;
    logic   r_halted;

    logic   w_aluop;
    logic   w_is_hlt;
    logic   w_is_skz;
    logic   w_is_jmp;
    logic   w_is_sto;
    logic   w_advance;

    logic   w_mem_rd;
    logic   w_mem_wr;
    logic   w_load_ir;
    logic   w_load_ac;
    logic   w_inc_pc;
    logic   w_load_pc;
    logic   w_halt;

    // A case decode lets an unknown opcode fall to default (no strobes)
    always_comb begin
        w_aluop  = 1'b0;
        w_is_hlt = 1'b0;
        w_is_skz = 1'b0;
        w_is_jmp = 1'b0;
        w_is_sto = 1'b0;
        case (bus.opcode)
            ADD, AND, XOR, LDA: w_aluop  = 1'b1;
            HLT:                w_is_hlt = 1'b1;
            SKZ:                w_is_skz = 1'b1;
            JMP:                w_is_jmp = 1'b1;
            STO:                w_is_sto = 1'b1;
            default:            ;
        endcase
    end

`ifdef CTRL_SINGLE_STEP_EN
    assign w_advance = (r_phase != INST_ADDR) || step;
`else
    assign w_advance = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_phase  <= INST_ADDR;
            r_halted <= 1'b0;
        end else if (!r_halted) begin
            if ((HALT_STICKY != 0) && (r_phase == OP_ADDR) && w_is_hlt) begin
                r_halted <= 1'b1;
            end else if (w_advance) begin
                r_phase <= phase_t'(r_phase + 3'd1);
            end
        end
    end

    always_comb begin
        w_mem_rd  = 1'b0;
        w_mem_wr  = 1'b0;
        w_load_ir = 1'b0;
        w_load_ac = 1'b0;
        w_inc_pc  = 1'b0;
        w_load_pc = 1'b0;
        w_halt    = 1'b0;
        if (r_halted) begin
            w_halt = 1'b1;
        end else begin
            case (r_phase)
                INST_ADDR:  ;
                INST_FETCH: w_mem_rd = 1'b1;
                INST_LOAD, IDLE: begin
                    w_mem_rd  = 1'b1;
                    w_load_ir = 1'b1;
                end
                OP_ADDR: begin
                    w_inc_pc = 1'b1;
                    w_halt   = w_is_hlt;
                end
                OP_FETCH:   w_mem_rd = w_aluop;
                ALU_OP: begin
                    w_load_ac = w_aluop;
                    w_mem_rd  = w_aluop;
                    w_inc_pc  = w_is_skz && bus.zero;
                    w_load_pc = w_is_jmp;
                end
                STORE: begin
                    w_load_ac = w_aluop;
                    w_mem_rd  = w_aluop;
                    w_inc_pc  = w_is_jmp;
                    w_load_pc = w_is_jmp;
                    w_mem_wr  = w_is_sto;
                end
                default:    ;
            endcase
        end
    end

    assign bus.mem_rd  = w_mem_rd;
    assign bus.mem_wr  = w_mem_wr;
    assign bus.load_ir = w_load_ir;
    assign bus.load_ac = w_load_ac;
    assign bus.inc_pc  = w_inc_pc;
    assign bus.load_pc = w_load_pc;
    assign bus.halt    = w_halt;
    assign bus.phase   = r_phase;

    always_ff @(posedge clk) begin
        if (rst_) begin
            assert (!(w_mem_rd && w_mem_wr));
            assert (!(r_phase >= OP_ADDR && !r_halted && $isunknown(bus.opcode)));
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_controller
// Description : Directed vector bench for cpu_controller.
// Revision    : 1.0  initial release
// ============================================================================
module tb_cpu_controller;
    import cpu_controller_pkg::*;

    logic clk;
    logic rst_;
    logic step;

    cpu_controller_if bus ();

    cpu_controller #(.HALT_STICKY(1)) dut (
        .clk  (clk),
        .rst_ (rst_),
`ifdef CTRL_SINGLE_STEP_EN
        .step (step),
`endif
        .bus  (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {mem_rd, mem_wr, load_ir, load_ac, inc_pc, load_pc, halt}
    typedef struct {
        opcode_t    op;
        logic       zero;
        logic [2:0] ph;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_checks;
    int   n_errors;

    function automatic logic [6:0] outs();
        return {bus.mem_rd, bus.mem_wr, bus.load_ir, bus.load_ac,
                bus.inc_pc, bus.load_pc, bus.halt};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // zero is inverted outside ALU_OP so a stray sample of it would show up
    task automatic add_instr(input opcode_t op, input logic z,
                             input logic [6:0] e5, input logic [6:0] e6, input logic [6:0] e7);
        logic [6:0] fetch [0:4];
        fetch[0] = 7'b0000000;
        fetch[1] = 7'b1000000;
        fetch[2] = 7'b1010000;
        fetch[3] = 7'b1010000;
        fetch[4] = 7'b0000100;
        for (int p = 0; p < 5; p++)
            vecs.push_back('{op, ~z, 3'(p), fetch[p]});
        vecs.push_back('{op, ~z, 3'd5, e5});
        vecs.push_back('{op,  z, 3'd6, e6});
        vecs.push_back('{op, ~z, 3'd7, e7});
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_       = 1'b0;
        step       = 1'b1;
        bus.opcode = ADD;
        bus.zero   = 1'b0;

        add_instr(ADD, 1'b0, 7'b1000000, 7'b1001000, 7'b1001000);
        add_instr(SKZ, 1'b1, 7'b0000000, 7'b0000100, 7'b0000000);
        add_instr(SKZ, 1'b0, 7'b0000000, 7'b0000000, 7'b0000000);
        add_instr(JMP, 1'b0, 7'b0000000, 7'b0000010, 7'b0000110);
        add_instr(STO, 1'b0, 7'b0000000, 7'b0000000, 7'b0100000);
        add_instr(LDA, 1'b1, 7'b1000000, 7'b1001000, 7'b1001000);
        add_instr(XOR, 1'b0, 7'b1000000, 7'b1001000, 7'b1001000);

        // In reset
        repeat (2) @(posedge clk);
        #1;
        check("reset_phase", {5'd0, bus.phase}, 8'd0);
        check("reset_outs",  {1'b0, outs()},    8'd0);
        rst_ = 1'b1;

        foreach (vecs[i]) begin
            bus.opcode = vecs[i].op;
            bus.zero   = vecs[i].zero;
            @(negedge clk);
            check($sformatf("vec%0d_%s_ph%0d_phase", i, vecs[i].op.name(), vecs[i].ph),
                  {5'd0, bus.phase}, {5'd0, vecs[i].ph});
            check($sformatf("vec%0d_%s_ph%0d_outs", i, vecs[i].op.name(), vecs[i].ph),
                  {1'b0, outs()}, {1'b0, vecs[i].exp});
            @(posedge clk);
            #1;
        end

        // Asynchronous reset in the middle of a store
        bus.opcode = STO;
        bus.zero   = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        check("sto_mem_wr_before_rst", {7'd0, bus.mem_wr}, 8'd1);
        #1 rst_ = 1'b0;
        #1;
        check("async_rst_mem_wr", {7'd0, bus.mem_wr}, 8'd0);
        check("async_rst_phase",  {5'd0, bus.phase},  8'd0);
        check("async_rst_outs",   {1'b0, outs()},     8'd0);
        @(posedge clk);
        #1 rst_ = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("post_rst_seq%0d", k), {5'd0, bus.phase}, 8'(k % 8));
        end

        // Sticky halt
        bus.opcode = HLT;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("hlt_phase4",      {5'd0, bus.phase}, 8'd4);
        check("hlt_phase4_outs", {1'b0, outs()},    8'b0000_0101);
        for (int k = 0; k < 22; k++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("halted_phase_c%0d", k), {5'd0, bus.phase}, 8'd4);
            check($sformatf("halted_outs_c%0d", k),  {1'b0, outs()},    8'b0000_0001);
        end
        #1 rst_ = 1'b0;
        #1;
        check("halt_rst_phase", {5'd0, bus.phase}, 8'd0);
        check("halt_rst_halt",  {7'd0, bus.halt},  8'd0);
        @(posedge clk);
        #1 rst_ = 1'b1;
        bus.opcode = ADD;
        @(negedge clk);
        check("halt_release_phase0", {5'd0, bus.phase}, 8'd0);
        @(posedge clk);
        @(negedge clk);
        check("halt_release_phase1", {5'd0, bus.phase}, 8'd1);
        check("halt_release_halt",   {7'd0, bus.halt},  8'd0);
        repeat (7) @(posedge clk);
        @(negedge clk);
        check("halt_release_wrap", {5'd0, bus.phase}, 8'd0);

`ifdef CTRL_SINGLE_STEP_EN
        step = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("step_wait_c%0d", k), {5'd0, bus.phase}, 8'd0);
            check($sformatf("step_wait_outs_c%0d", k), {1'b0, outs()}, 8'd0);
        end
        step = 1'b1;
        @(posedge clk);
        #1 step = 1'b0;
        @(negedge clk);
        check("step_pass_ph1", {5'd0, bus.phase}, 8'd1);
        for (int k = 2; k <= 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("step_pass_ph%0d", k % 8), {5'd0, bus.phase}, 8'(k % 8));
        end
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("step_hold_c%0d", k), {5'd0, bus.phase}, 8'd0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
